// File: rtl/sum_deser.sv
// Deserializer for the bit-serial adder: gathers LSB-first sum bits plus the
// final carry into a parallel result, offered on a valid/ready handshake.
module sum_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic             sof,
    input  logic             sum_bit,
    input  logic             carry_bit,
    input  logic             res_ready,
    input  logic             clr_err,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             res_valid,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned IDX_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;
    logic               start_frame;
    logic               last_bit;

    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Next-state, datapath and sticky-flag logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        result_d    = result_q;
        carry_d     = carry_q;
        valid_d     = valid_q;
        ovr_d       = clr_err ? 1'b0 : ovr_q;
        ferr_d      = clr_err ? 1'b0 : ferr_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                start_frame = bit_valid && sof;
            end
            SHIFT: begin
                if (bit_valid) begin
                    if (sof) begin
                        ferr_d      = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < WIDTH; i++) begin
                            if (idx_q == IDX_W'(i)) begin
                                result_d[i] = sum_bit;
                            end
                        end
                        if (last_bit) begin
                            carry_d = carry_bit;
                            idx_d   = '0;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            HOLD: begin
                if (res_ready) begin
                    valid_d     = 1'b0;
                    state_d     = IDLE;
                    start_frame = bit_valid && sof;
                end else if (bit_valid) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                valid_d = 1'b0;
            end
        endcase

        // A new frame overwrites bit 0 and clears the stale upper bits
        if (start_frame) begin
            result_d = WIDTH'(sum_bit);
            if (WIDTH == 1) begin
                carry_d = carry_bit;
                idx_d   = '0;
                valid_d = 1'b1;
                state_d = HOLD;
            end else begin
                idx_d   = IDX_W'(1);
                valid_d = 1'b0;
                state_d = SHIFT;
            end
        end
    end

    assign result    = result_q;
    assign carry_out = carry_q;
    assign res_valid = valid_q;
    assign overrun   = ovr_q;
    assign frame_err = ferr_q;

endmodule
